// File: rtl/wishbone_master_if.sv
// rtl/wishbone_master_if.sv - CPU-to-Wishbone classic-cycle master bridge with err/timeout termination
// Optional feature macro: WB_POSTED_WRITE_EN (posted writes with sticky error)
module wishbone_master_if #(
   parameter int DW     = 32,
   parameter int AW     = 32,
   parameter int TO_CYC = 255
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [5:0]      stall_i,
   input  logic            flush_i,
   input  logic            cpu_ce_i,
   input  logic            cpu_we_i,
   input  logic [AW-1:0]   cpu_addr_i,
   input  logic [DW-1:0]   cpu_data_i,
   input  logic [DW/8-1:0] cpu_sel_i,
   output logic [DW-1:0]   cpu_data_o,
   output logic            cpu_err_o,
   output logic            stallreq,
   input  logic [DW-1:0]   wishbone_data_i,
   input  logic            wishbone_ack_i,
   input  logic            wishbone_err_i,
   output logic [AW-1:0]   wishbone_addr_o,
   output logic [DW-1:0]   wishbone_data_o,
   output logic            wishbone_we_o,
   output logic [DW/8-1:0] wishbone_sel_o,
   output logic            wishbone_stb_o,
   output logic            wishbone_cyc_o
);

   localparam int CW = (TO_CYC > 0) ? $clog2(TO_CYC + 1) : 1;
   localparam logic [CW-1:0] TO_LAST = (TO_CYC > 0) ? CW'(TO_CYC - 1) : '0;

   typedef enum logic [1:0] {
      IDLE           = 2'd0,
      BUSY           = 2'd1,
      WAIT_FOR_STALL = 2'd2
   } state_t;

   state_t          state, state_nxt;
   logic [CW-1:0]   cnt;
   logic [DW-1:0]   rd_buf;
   logic            err_buf;
   logic            issue, timeout, term, term_err, read_ack, posted_req;
   logic            posted_q, err_sticky;

   assign issue    = (state == IDLE) && cpu_ce_i && !flush_i;
   assign timeout  = (TO_CYC != 0) && (cnt == TO_LAST);
   assign term     = (state == BUSY) && (wishbone_ack_i || wishbone_err_i || timeout);
   assign term_err = wishbone_err_i || timeout;
   // err has priority over a simultaneous ack, so no data is returned then
   assign read_ack = wishbone_ack_i && !wishbone_err_i && !wishbone_we_o;

`ifdef WB_POSTED_WRITE_EN
   assign posted_req = cpu_we_i;

   always_ff @(posedge clk) begin
      if (rst) begin
         posted_q   <= 1'b0;
         err_sticky <= 1'b0;
      end else if (issue) begin
         posted_q   <= cpu_we_i;
         err_sticky <= 1'b0;
      end else if (term && posted_q) begin
         posted_q   <= 1'b0;
         err_sticky <= err_sticky | term_err;
      end
   end
`else
   assign posted_req = 1'b0;
   assign posted_q   = 1'b0;
   assign err_sticky = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:           if (issue) state_nxt = BUSY;
         BUSY: begin
            if (term) begin
               if (!posted_q && (stall_i != 6'd0)) state_nxt = WAIT_FOR_STALL;
               else                                state_nxt = IDLE;
            end
         end
         WAIT_FOR_STALL: if (stall_i == 6'd0) state_nxt = IDLE;
         default:        state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wishbone_addr_o <= '0;
         wishbone_data_o <= '0;
         wishbone_we_o   <= 1'b0;
         wishbone_sel_o  <= '0;
         wishbone_stb_o  <= 1'b0;
         wishbone_cyc_o  <= 1'b0;
         rd_buf          <= '0;
         err_buf         <= 1'b0;
         cnt             <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (issue) begin
                  wishbone_addr_o <= cpu_addr_i;
                  wishbone_data_o <= cpu_data_i;
                  wishbone_we_o   <= cpu_we_i;
                  wishbone_sel_o  <= cpu_sel_i;
                  wishbone_stb_o  <= 1'b1;
                  wishbone_cyc_o  <= 1'b1;
                  rd_buf          <= '0;
                  err_buf         <= 1'b0;
                  cnt             <= '0;
               end
            end
            BUSY: begin
               if (term) begin
                  wishbone_addr_o <= '0;
                  wishbone_data_o <= '0;
                  wishbone_we_o   <= 1'b0;
                  wishbone_sel_o  <= '0;
                  wishbone_stb_o  <= 1'b0;
                  wishbone_cyc_o  <= 1'b0;
                  if (posted_q || (flush_i && (stall_i == 6'd0))) begin
                     rd_buf  <= '0;
                     err_buf <= 1'b0;
                  end else begin
                     rd_buf  <= read_ack ? wishbone_data_i : '0;
                     err_buf <= term_err;
                  end
               end else if (cnt != '1) begin
                  cnt <= cnt + CW'(1);
               end
            end
            WAIT_FOR_STALL: begin
            end
            default: begin
               wishbone_addr_o <= '0;
               wishbone_data_o <= '0;
               wishbone_we_o   <= 1'b0;
               wishbone_sel_o  <= '0;
               wishbone_stb_o  <= 1'b0;
               wishbone_cyc_o  <= 1'b0;
            end
         endcase
      end
   end

   always_comb begin
      stallreq   = 1'b0;
      cpu_data_o = '0;
      cpu_err_o  = 1'b0;
      if (!rst) begin
         case (state)
            IDLE: begin
               stallreq  = issue && !posted_req;
               cpu_err_o = err_sticky;
            end
            BUSY: begin
               if (posted_q) begin
                  // a request arriving behind a posted write waits for it to finish
                  stallreq  = cpu_ce_i;
                  cpu_err_o = err_sticky | (term & term_err);
               end else begin
                  stallreq   = !term;
                  cpu_data_o = (term && read_ack) ? wishbone_data_i : '0;
                  cpu_err_o  = term && term_err;
               end
            end
            WAIT_FOR_STALL: begin
               cpu_data_o = rd_buf;
               cpu_err_o  = err_buf;
            end
            default: begin
            end
         endcase
      end
   end

endmodule
